ahb_mem_slave: RTL and testbench
================================

// Module: ahb_mem_slave
// PURPOSE
//  Parametrised AHB-Lite memory slave: on-chip word array behind AHB with configurable data width, depth and wait states.
//  Adds sub-word writes, a wait-state generator and a two-cycle ERROR response for bad transfers.
//  Sits behind the decoder/mux; its HREADYOUT feeds the bus HREADY mux.
// PARAMETERS
//  DATA_W       32    bus/memory word width; 32 or 64
//  MEM_DEPTH    1024  words in array; addressable bytes = MEM_DEPTH*DATA_W/8
//  WAIT_STATES  0     data-phase wait cycles per OKAY transfer, 0..7
// PORTS
//  HCLK       in   1       clock
//  HRESETn    in   1       asynchronous, active-low reset
//  HSEL       in   1       slave select from decoder
//  HADDR      in   32      address (byte offset from slave base)
//  HTRANS     in   2       IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1       1=write
//  HSIZE      in   3       transfer size, bytes = 2**HSIZE
//  HBURST     in   3       accepted, unused (each beat handled independently)
//  HWDATA     in   DATA_W  write data, valid in data phase
//  HREADY     in   1       bus ready (muxed)
//  HRDATA     out  DATA_W  read data
//  HREADYOUT  out  1       slave ready
//  HRESP      out  2       OKAY=00, ERROR=01
// BEHAVIOUR
//  - Reset: state IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, wait counter=0. Array NOT reset (contents X).
//  - Accept = HSEL & HREADY & HTRANS[1]; address-phase regs (addr, write, size) load only on accept.
//  - Error check at accept: offset >= MEM_DEPTH*DATA_W/8, or 2**HSIZE > DATA_W/8, or HADDR not aligned to 2**HSIZE.
//  - FSM (evaluated each HCLK):
//    IDLE : HREADYOUT=1 OKAY. Accept&ok -> DATA (cnt=0); accept&err -> ERR1; else IDLE.
//    DATA : HREADYOUT = (cnt==WAIT_STATES); cnt++ while low. On final cycle: accept&ok -> DATA (cnt=0),
//           accept&err -> ERR1, else IDLE.
//    ERR1 : HREADYOUT=0, HRESP=ERROR -> ERR2 unconditionally.
//    ERR2 : HREADYOUT=1, HRESP=ERROR; accept handled as in IDLE. Array never written by errored transfer.
//  - WAIT_STATES=0: zero-wait pipelined, back-to-back transfers at 1/cycle.
//  - BUSY/IDLE HTRANS or HSEL=0: no accept; OKAY zero-wait response.
//  - Write: HWDATA sampled on final DATA cycle; array updated at that edge.
//    Byte lane i (0..DATA_W/8-1) enabled iff addr_lo <= i < addr_lo+2**size, addr_lo = addr[log2(DATA_W/8)-1:0].
//  - Read: HRDATA = mem[addr_reg word index] combinationally during read DATA state (full word, all lanes);
//    HRDATA=0 in all other states.
//  - Write then read same word back-to-back: read data phase follows write completion edge -> returns new data; no forwarding needed.
//  - Word index = addr_reg[log2(DATA_W/8) +: log2(MEM_DEPTH)]; upper bits covered by range check.
//  - Reset mid-transfer: FSM to IDLE immediately; in-flight write dropped.
//  - HREADY low while in IDLE/ERR2 (another slave stalling): no accept, state held.
// STRUCTURE
//  - ahb_pkg: HTRANS/HRESP/HSIZE encodings, state enum {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2}.
//  - Sub-module ahb_byte_strobe_gen: (addr_lo, size) -> DATA_W/8 lane enables; reused by other slaves.
//  - Array: reg [DATA_W-1:0] mem[MEM_DEPTH]; byte-lane write loop.
// TESTING
//  1. Reset, then idle: HREADYOUT=1, HRESP=00, HRDATA=0 for 10 cycles, HTRANS=IDLE.
//  2. WAIT_STATES=0: write word 0xDEADBEEF @0x10, read @0x10 next cycle -> HRDATA=0xDEADBEEF, no stall.
//  3. Byte/half writes: write 0xAA size=0 @0x21, 0x5566 size=1 @0x22 onto 0x00000000 @0x20 -> read 0x5566AA00.
//  4. WAIT_STATES=3: single read -> HREADYOUT low exactly 3 cycles then high with data; back-to-back read repeats.
//  5. Errors: read @MEM_DEPTH*4, word write @0x02, size=3 on DATA_W=32 -> each ERR1 (0/01) then ERR2 (1/01); target memory unchanged.
//  6. Assert HRESETn mid-wait-state of a write to 0x40 -> HREADYOUT=1 immediately; 0x40 not updated by the aborted write.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave FSM state type.
// Contents: HTRANS / HRESP / HSIZE encodings, state_t.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// Byte-lane enable generator for AHB sub-word transfers.
// Ports:
//   addr_lo  in   low address bits selecting the first lane
//   size     in   HSIZE, transfer is 2**size bytes
//   strobe   out  one enable per byte lane of a DATA_W bus
module ahb_byte_strobe_gen #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo,
    input  logic [2:0]                  size,
    output logic [DATA_W/8-1:0]         strobe
);

    localparam int LANES = DATA_W / 8;

    always_comb begin
        strobe = '0;
        for (int i = 0; i < LANES; i++) begin
            strobe[i] = (i >= int'(addr_lo)) && (i < int'(addr_lo) + (1 << size));
        end
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word array with sub-word writes, programmable wait
// states and a two-cycle ERROR response for out-of-range, oversized or
// misaligned transfers.
// Ports:
//   HCLK, HRESETn              clock, async active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST      address phase (HBURST ignored)
//   HWDATA                     write data, data phase
//   HREADY                     muxed bus ready
//   HRDATA, HREADYOUT, HRESP   slave response
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic [1:0]        HRESP
);

    localparam int unsigned LANES     = DATA_W / 8;
    localparam int unsigned LO_W      = $clog2(LANES);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = MEM_DEPTH * LANES;
    localparam logic [2:0]  WAIT_LAST = 3'(WAIT_STATES);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic [1:0]  resp_q;
    logic [31:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic              xfer_err;
    logic [31:0]       size_bytes;
    logic              data_last;
    logic              mem_we;
    logic [IDX_W-1:0]  word_idx;
    logic [LANES-1:0]  strobe;

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign size_bytes = 32'd1 << HSIZE;
    assign xfer_err   = (HADDR >= MEM_BYTES) || (size_bytes > LANES) ||
                        ((HADDR & (size_bytes - 32'd1)) != 32'd0);
    assign data_last  = (state_q == ST_DATA) && (cnt_q == WAIT_LAST);
    assign mem_we     = data_last && write_q;
    assign word_idx   = addr_q[LO_W +: IDX_W];

    ahb_byte_strobe_gen #(
        .DATA_W (DATA_W)
    ) u_strobe (
        .addr_lo (addr_q[LO_W-1:0]),
        .size    (size_q),
        .strobe  (strobe)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else if (state_q == ST_ERR1) begin
            state_q <= ST_ERR2;
            ready_q <= 1'b1;
            resp_q  <= HRESP_ERROR;
        end else if ((state_q == ST_DATA) && !data_last) begin
            cnt_q   <= cnt_q + 3'd1;
            ready_q <= ((cnt_q + 3'd1) == WAIT_LAST);
        end else if (accept) begin
            // Reached from IDLE, ERR2 or the final DATA cycle: all launch alike.
            addr_q  <= HADDR;
            write_q <= HWRITE;
            size_q  <= HSIZE;
            cnt_q   <= 3'd0;
            if (xfer_err) begin
                state_q <= ST_ERR1;
                ready_q <= 1'b0;
                resp_q  <= HRESP_ERROR;
            end else begin
                state_q <= ST_DATA;
                ready_q <= (WAIT_LAST == 3'd0);
                resp_q  <= HRESP_OKAY;
            end
        end else if ((state_q == ST_ERR2) && !HREADY) begin
            // Another slave is stalling the bus: hold the ERROR response.
            state_q <= ST_ERR2;
        end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end
    end

    // Array intentionally has no reset.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (strobe[i]) begin
                    mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? mem[word_idx] : '0;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HBURST, addr_q[31:LO_W+IDX_W]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) share the bus and are
// selected in turn; a byte-addressed reference memory predicts every response.
module tb_ahb_mem_slave;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        sel;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rd0, rd3;

    always #5 clk = ~clk;

    assign hready = sel ? rdy3 : rdy0;
    assign hresp  = sel ? resp3 : resp0;
    assign hrdata = sel ? rd3 : rd0;

    ahb_mem_slave #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel & ~sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(hready), .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    ahb_mem_slave #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel & sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HWDATA(hwdata), .HREADY(hready), .HRDATA(rd3), .HREADYOUT(rdy3), .HRESP(resp3)
    );

    typedef struct {
        bit          gap;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    op_t         ops[$];
    logic [7:0]  ref_mem [2][256];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        longint unsigned n = 64'd1 << s;
        return (a >= DEPTH * 4) || (n > 4) || ((a % n) != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned b = a & ~32'd3;
        return {ref_mem[sel][b+3], ref_mem[sel][b+2], ref_mem[sel][b+1], ref_mem[sel][b]};
    endfunction

    task automatic model_write(input op_t o);
        int unsigned n  = 1 << o.size;
        int unsigned lo = o.addr % 4;
        for (int unsigned b = 0; b < n; b++) ref_mem[sel][o.addr+b] = o.wdata[8*(lo+b) +: 8];
    endtask

    task automatic idle_drive();
        hsel   = 1'($urandom_range(0, 1));
        htrans = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom);
        hwrite = 1'($urandom);
        haddr  = $urandom;
        hsize  = 3'($urandom);
        hburst = 3'($urandom);
    endtask

    task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d);
        op_t o;
        o.gap = 1'b0; o.wr = wr; o.addr = a; o.size = s; o.wdata = d;
        ops.push_back(o);
    endtask

    task automatic push_gap();
        op_t o;
        o.gap = 1'b1; o.wr = 1'b0; o.addr = '0; o.size = '0; o.wdata = '0;
        ops.push_back(o);
    endtask

    // Pipelined master: called just after a rising edge, returns the same way.
    task automatic run_ops();
        bit          dp_v = 0;
        bit          dp_err = 0;
        op_t         dp;
        int          k = 0;
        int          ai = 0;
        int          ws = sel ? 3 : 0;
        while (ai < ops.size() || dp_v) begin
            if (ai < ops.size() && !ops[ai].gap) begin
                hsel = 1'b1; htrans = 2'b10; hwrite = ops[ai].wr;
                haddr = ops[ai].addr; hsize = ops[ai].size; hburst = 3'($urandom);
            end else begin
                idle_drive();
            end
            hwdata = (dp_v && dp.wr) ? dp.wdata : $urandom;
            @(negedge clk);
            if (dp_v) begin
                chk("hreadyout", 64'(hready), dp_err ? 64'(k == 1) : 64'(k >= ws));
                chk("hresp", 64'(hresp), dp_err ? 64'd1 : 64'd0);
                if (!dp_err && !dp.wr) chk("hrdata", 64'(hrdata), 64'(model_read(dp.addr)));
                else chk("hrdata_zero", 64'(hrdata), 64'd0);
                if (!dp_err && !dp.wr && hready) last_rdata = hrdata;
            end else begin
                chk("idle_ready", 64'(hready), 64'd1);
                chk("idle_resp", 64'(hresp), 64'd0);
                chk("idle_rdata", 64'(hrdata), 64'd0);
            end
            if (hready) begin
                if (dp_v && !dp_err && dp.wr) model_write(dp);
                dp_v = 0;
                if (ai < ops.size()) begin
                    if (!ops[ai].gap) begin
                        dp_v = 1; dp = ops[ai]; dp_err = is_err(dp.addr, dp.size); k = 0;
                    end
                    ai++;
                end
            end else begin
                k++;
                if (k > 12) begin
                    checks++; errors++;
                    $error("FAIL stall_timeout observed=%0d cycles expected<=%0d", k, ws);
                    dp_v = 0; ai = ops.size();
                end
            end
            @(posedge clk); #1;
        end
        idle_drive();
        ops.delete();
    endtask

    task automatic add_rand(input int n);
        for (int i = 0; i < n; i++) begin
            int          r = $urandom_range(0, 9);
            logic [2:0]  s = 3'($urandom_range(0, 2));
            logic [31:0] a = $urandom_range(0, 63);
            if ($urandom_range(0, 5) == 0) begin
                push_gap();
                continue;
            end
            a = a & ~((32'd1 << s) - 32'd1);
            if (r == 0) a = a + 256 + $urandom_range(0, 1000);
            else if (r == 1) s = 3'd3;
            else if (r == 2 && s != 3'd0) a = a | 32'd1;
            push(1'($urandom), a, s, $urandom);
        end
    endtask

    initial begin
        sel = 1'b0;
        hresetn = 1'b0;
        hwdata = '0;
        idle_drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        hresetn = 1'b1;

        // Idle after reset, both slaves
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; idle_drive();
            @(negedge clk);
            chk("rst_ready0", 64'(rdy0), 64'd1);
            chk("rst_resp0", 64'(resp0), 64'd0);
            chk("rst_rdata0", 64'(rd0), 64'd0);
            chk("rst_ready3", 64'(rdy3), 64'd1);
            chk("rst_resp3", 64'(resp3), 64'd0);
            chk("rst_rdata3", 64'(rd3), 64'd0);
        end
        @(posedge clk); #1;

        // Zero-wait write then read back-to-back
        push(1, 32'h10, 3'd2, 32'hDEADBEEF);
        push(0, 32'h10, 3'd2, 32'h0);
        run_ops();
        chk("wr_rd_b2b", 64'(last_rdata), 64'hDEADBEEF);

        // Byte and halfword merge
        push(1, 32'h20, 3'd2, 32'h0);
        push(1, 32'h21, 3'd0, 32'h0000AA00);
        push(1, 32'h22, 3'd1, 32'h55660000);
        push(0, 32'h20, 3'd2, 32'h0);
        run_ops();
        chk("subword_merge", 64'(last_rdata), 64'h5566AA00);

        // Error responses leave memory untouched
        push(1, 32'h00, 3'd2, 32'h12345678);
        push(1, 32'h08, 3'd2, 32'h9ABCDEF0);
        push(0, DEPTH * 4, 3'd2, 32'h0);
        push(1, 32'h02, 3'd2, 32'hFFFFFFFF);
        push(1, 32'h08, 3'd3, 32'hFFFFFFFF);
        push(0, 32'h00, 3'd2, 32'h0);
        run_ops();
        chk("err_misaligned_nowrite", 64'(last_rdata), 64'h12345678);
        push(0, 32'h08, 3'd2, 32'h0);
        run_ops();
        chk("err_oversize_nowrite", 64'(last_rdata), 64'h9ABCDEF0);

        // Random traffic on the zero-wait slave
        for (int w = 0; w < 16; w++) push(1, 32'(w * 4), 3'd2, $urandom);
        add_rand(120);
        run_ops();

        // Three wait states
        sel = 1'b1;
        push(1, 32'h00, 3'd2, 32'hA5A5_0F0F);
        push_gap();
        push(0, 32'h00, 3'd2, 32'h0);
        push_gap();
        push(0, 32'h00, 3'd2, 32'h0);
        push(0, 32'h00, 3'd2, 32'h0);
        run_ops();
        chk("ws3_read", 64'(last_rdata), 64'hA5A50F0F);

        for (int w = 0; w < 16; w++) push(1, 32'(w * 4), 3'd2, $urandom);
        add_rand(80);
        run_ops();

        // Reset during the wait states of a write
        push(1, 32'h40, 3'd2, 32'hCAFEF00D);
        run_ops();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        @(posedge clk); #1;
        idle_drive();
        hwdata = 32'h0BADF00D;
        @(negedge clk);
        chk("abort_stalled", 64'(hready), 64'd0);
        @(posedge clk); #1;
        hresetn = 1'b0;
        #1;
        chk("abort_ready", 64'(hready), 64'd1);
        chk("abort_resp", 64'(hresp), 64'd0);
        @(negedge clk); @(negedge clk);
        hresetn = 1'b1;
        @(posedge clk); #1;
        push(0, 32'h40, 3'd2, 32'h0);
        run_ops();
        chk("abort_nowrite", 64'(last_rdata), 64'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
